mem_copy_engine: RTL

Block-copy initiator that drives the single-port 256x8 data memory: it reads bytes from a source range and writes them to a destination range, one memory access per cycle. It sits between the core's control logic (Start/Busy/Done handshake) and the data memory's address/write-enable/data ports. It arbitrates nothing; while Busy it owns the memory port.

---
 rtl/mem_copy_pkg.sv | 21 ++
 rtl/mem_copy_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and helpers for the block-copy engine: FSM state encoding,
// default widths, and the copy-direction decision.
package mem_copy_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_A = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // gap = (dst - src) mod 2**A. A copy whose destination starts inside the
    // source range must run back-to-front so unread source bytes survive.
    function automatic logic copy_descends(input logic [31:0] gap, input logic [31:0] len);
        return (gap != 32'd0) && (gap < len);
    endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Block-copy initiator for a single-port memory: one read or one write per
// cycle, memmove semantics. Optional running byte checksum: MEM_COPY_CHECKSUM_EN.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int A = DEF_A
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Len,
    output logic         Busy,
    output logic         Done,
    output logic [A-1:0] MemAddr,
    output logic         MemWriteEn,
    output logic [W-1:0] MemWData,
    input  logic [W-1:0] MemRData
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [W-1:0] Checksum
`endif
);

    localparam logic [A-1:0] ONE_A = {{(A-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A-1:0] len_q, len_d;
    logic [A-1:0] cnt_q, cnt_d;
    logic         desc_q, desc_d;
    logic [W-1:0] buf_q, buf_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         we_q, we_d;
    logic [A-1:0] addr_q, addr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic [A-1:0] gap_s;
    logic         desc_s;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [W-1:0] sum_q, sum_d;
`endif

    assign gap_s  = DstAddr - SrcAddr;
    assign desc_s = copy_descends(32'(gap_s), 32'(Len));

    // Next-state and datapath update; outputs are then decoded from the next
    // state so every memory-facing signal leaves a flop.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        desc_d  = desc_q;
        buf_d   = buf_q;
`ifdef MEM_COPY_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    len_d   = Len;
                    cnt_d   = '0;
                    desc_d  = desc_s;
                    src_d   = desc_s ? (SrcAddr + Len - ONE_A) : SrcAddr;
                    dst_d   = desc_s ? (DstAddr + Len - ONE_A) : DstAddr;
`ifdef MEM_COPY_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = (Len != '0) ? READ : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                buf_d   = MemRData;
                state_d = WRITE;
            end
            WRITE: begin
                cnt_d = cnt_q + ONE_A;
                if (desc_q) begin
                    src_d = src_q - ONE_A;
                    dst_d = dst_q - ONE_A;
                end else begin
                    src_d = src_q + ONE_A;
                    dst_d = dst_q + ONE_A;
                end
`ifdef MEM_COPY_CHECKSUM_EN
                sum_d   = sum_q + buf_q;
`endif
                state_d = (cnt_d == len_q) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = 1'b0;
        done_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = buf_d;
        case (state_d)
            READ: begin
                busy_d = 1'b1;
                addr_d = src_d;
            end
            WRITE: begin
                busy_d = 1'b1;
                we_d   = 1'b1;
                addr_d = dst_d;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; Reset clears everything at once.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            desc_q  <= 1'b0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            desc_q  <= desc_d;
            buf_q   <= buf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MEM_COPY_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign MemWriteEn = we_q;
    assign MemAddr    = addr_q;
    assign MemWData   = wdata_q;
`ifdef MEM_COPY_CHECKSUM_EN
    assign Checksum   = sum_q;
`endif

endmodule
